updown_counter_param: RTL
=========================

Name: updown_counter_param

Overview:
Parametrised successor to the fixed 4-bit up/down counter. Provides a WIDTH-bit modulo-(MAX_VAL+1) up/down counter with count enable, synchronous parallel load, selectable wrap or saturate mode, a terminal-count flag, overflow/underflow event pulses and a sticky error flag. Used as a general event/position counter in datapath and control blocks, and driven directly by the team's PATTERN-style benches.

Parameters:
WIDTH, 4, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest legal count; counting range is 0..MAX_VAL; must be <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count enable
ctrl  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
clr_err  input  1  clears sticky err
cnt  output  WIDTH  registered count
tc  output  1  terminal count (combinational)
ovf  output  1  registered one-cycle pulse: up-count attempted past MAX_VAL
udf  output  1  registered one-cycle pulse: down-count attempted below 0
err  output  1  sticky: set by any ovf/udf event

Behaviour:
- Clock and reset fixed: single clock clk; rst synchronous, active-high.
- Reset: cnt=0, ovf=0, udf=0, err=0; rst overrides all other inputs, including mid-count or mid-load.
- Priority per edge: rst > load > en. ctrl is ignored unless en=1 and load=0.
- Load: cnt <= min(load_val, MAX_VAL); an out-of-range load_val clamps to MAX_VAL and sets no flags. ovf=udf=0 on a load cycle.
- Count, en=1, ctrl=1: if cnt<MAX_VAL then cnt+1; if cnt==MAX_VAL then cnt<=0 (SATURATE=0) or hold (SATURATE=1); ovf=1 for that cycle in both modes.
- Count, en=1, ctrl=0: if cnt>0 then cnt-1; if cnt==0 then cnt<=MAX_VAL (SATURATE=0) or hold at 0 (SATURATE=1); udf=1 for that cycle in both modes.
- en=0 and load=0: cnt holds; ovf=udf=0.
- ovf and udf are registered and valid on the cycle cnt shows the post-event value; both are never high together.
- tc = (ctrl & cnt==MAX_VAL) | (~ctrl & cnt==0); independent of en; zero latency.
- err: set on the edge where ovf or udf is set; cleared by clr_err. If clr_err is high in the same cycle as a new event, set wins (err=1).
- Latency: 1 cycle from en/load to cnt.
- Arithmetic stays within WIDTH bits; no intermediate carry is exposed. When MAX_VAL < 2**WIDTH-1, values above MAX_VAL are unreachable.

Optional Feature:
Macro UPDOWN_CNT_GRAY_EN. When defined: adds output cnt_gray [WIDTH-1:0], registered, equal to binary-to-Gray of the next cnt and updated on the same edge, so cnt_gray == cnt ^ (cnt>>1) at all times; reset value 0. For safe cross-domain sampling, MAX_VAL must be 2**WIDTH-1 when this macro is used. When not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0: rst=1 for 2 cycles, then en=1, ctrl=1 for 12 cycles -> cnt 1..9,0,1,2; ovf=1 only on the cycle cnt=0; err=1 from then on.
- Same config, cnt=0, en=1, ctrl=0 -> cnt=9, udf=1 for one cycle; tc=1 while cnt=0 with ctrl=0.
- SATURATE=1, MAX_VAL=9: count up from 8 for 3 cycles -> cnt 9,9,9; ovf pulses on the 2nd and 3rd cycles; count down from 0 -> cnt stays 0, udf=1.
- load=1, load_val=13, MAX_VAL=9, en=1 in the same cycle -> cnt=9, ovf=udf=0; then load_val=5 with load=1 -> cnt=5.
- Mid-count rst=1 with load=1 and en=1 at cnt=6 -> cnt=0, err=0 next cycle; clr_err=1 coincident with an overflow -> err stays 1.
- With UPDOWN_CNT_GRAY_EN, WIDTH=4, MAX_VAL=15: count up 0..15 -> cnt_gray changes exactly one bit per step, and cnt_gray=4'b1000 at cnt=15.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: WIDTH-bit modulo-(MAX_VAL+1) up/down counter.
// Supports count enable, a synchronous parallel load that clamps to MAX_VAL,
// wrap or saturate behaviour at the range ends, and a combinational
// terminal-count flag. It also provides registered overflow/underflow pulses
// and a sticky error flag.
// Optional feature: define UPDOWN_CNT_GRAY_EN to add a registered Gray-coded
// copy of the count (cnt_gray). Use this only with MAX_VAL == 2**WIDTH-1.
module updown_counter_param #(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             udf,
  output logic             err
`ifdef UPDOWN_CNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] cnt_gray
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             err_q, err_d;

  // Next count and event pulses: load beats count; range ends wrap or hold
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (ctrl) begin
        if (cnt_q == MAX_VAL) begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          udf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? cnt_q : MAX_VAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Sticky error: a new event wins over a coincident clear
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (ovf_d || udf_d) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset overriding load and count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      err_q <= err_d;
    end
  end

`ifdef UPDOWN_CNT_GRAY_EN
  logic [WIDTH-1:0] gray_q, gray_d;

  // Gray code of the next count, so it tracks cnt on the same edge
  always_comb begin
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  // Gray register, cleared alongside the count
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign cnt_gray = gray_q;
`endif

  // Terminal count looks at the current direction, not at enable
  always_comb begin
    tc = ctrl ? (cnt_q == MAX_VAL) : (cnt_q == '0);
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
  assign udf = udf_q;
  assign err = err_q;

endmodule
